// File: rtl/pc_counter.sv
// pc_counter: up/down counter with auto-run toward a terminal value,
// wrapping or saturating at the 0 / 2^WIDTH-1 bounds.
module pc_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  input  logic             start,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] out_q, up_d, dn_d;
  logic             done_q, wrap_q, top, bot;
  assign up_d = out_q + WIDTH'(1);
  assign dn_d = out_q - WIDTH'(1);
  assign top  = &out_q;
  assign bot  = ~|out_q;
  // A step past a bound always pulses wrap; saturation also freezes out and ends a run without done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (clear) begin
        out_q   <= '0;
        state_q <= IDLE;
      end else if (load) begin
        out_q   <= in;
        state_q <= IDLE;
      end else if (state_q == RUN) begin
        if (SATURATE && top) begin
          wrap_q  <= 1'b1;
          state_q <= IDLE;
        end else begin
          out_q  <= up_d;
          wrap_q <= top;
          if (up_d == term) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
      end else if (start) begin
        if (out_q == term) done_q <= 1'b1;
        else state_q <= RUN;
      end else if (inc && !dec) begin
        wrap_q <= top;
        if (!(SATURATE && top)) out_q <= up_d;
      end else if (dec && !inc) begin
        wrap_q <= bot;
        if (!(SATURATE && bot)) out_q <= dn_d;
      end
    end
  end
  assign out  = out_q;
  assign tc   = (out_q == term);
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_pc_counter.sv
// tb_pc_counter: directed and randomized checks of pc_counter in wrap and saturate builds.
module tb_pc_counter;
  logic        clock = 1'b0, reset_n = 1'b0, clear = 1'b0, load = 1'b0;
  logic        inc = 1'b0, dec = 1'b0, start = 1'b0;
  logic [15:0] in = '0, term = '0;
  logic [15:0] out0, out1;
  logic        tc0, tc1, busy0, busy1, done0, done1, wrap0, wrap1;
  int          passed = 0, total = 0;
  int          m_out [2];
  bit          m_run [2], m_done [2], m_wrap [2];

  always #5 clock = ~clock;

  pc_counter #(.WIDTH(16), .SATURATE(1'b0)) u0 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load), .in(in), .inc(inc),
    .dec(dec), .start(start), .term(term), .out(out0), .tc(tc0), .busy(busy0),
    .done(done0), .wrap(wrap0));
  pc_counter #(.WIDTH(16), .SATURATE(1'b1)) u1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load), .in(in), .inc(inc),
    .dec(dec), .start(start), .term(term), .out(out1), .tc(tc1), .busy(busy1),
    .done(done1), .wrap(wrap1));

  // Reference: integer count, run flag, and pulses derived from the counter rules.
  task automatic tick();
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      int n;
      m_done[k] = 1'b0;
      m_wrap[k] = 1'b0;
      if (clear) begin
        m_out[k] = 0; m_run[k] = 1'b0;
      end else if (load) begin
        m_out[k] = int'(in); m_run[k] = 1'b0;
      end else if (m_run[k]) begin
        n = m_out[k] + 1;
        if (n > 65535 && k == 1) begin
          m_wrap[k] = 1'b1; m_run[k] = 1'b0;
        end else begin
          m_wrap[k] = (n > 65535);
          m_out[k]  = n % 65536;
          m_done[k] = (m_out[k] == int'(term));
          m_run[k]  = !m_done[k];
        end
      end else if (start) begin
        m_done[k] = (m_out[k] == int'(term));
        m_run[k]  = !m_done[k];
      end else if (inc != dec) begin
        n = inc ? m_out[k] + 1 : m_out[k] - 1;
        m_wrap[k] = (n < 0 || n > 65535);
        if (!(m_wrap[k] && k == 1)) m_out[k] = (n + 65536) % 65536;
      end
    end
    @(negedge clock);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = 0; m_run[k] = 1'b0; m_done[k] = 1'b0; m_wrap[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    total++; if (out0 !== 16'h0 || out1 !== 16'h0) $display("FAIL reset_out got %h/%h exp 0000", out0, out1); else passed++;
    total++; if ({busy0, done0, wrap0, busy1, done1, wrap1} !== 6'b0) $display("FAIL reset_flags got %b exp 000000", {busy0, done0, wrap0, busy1, done1, wrap1}); else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    total++; if (out0 !== 16'h0 || busy0 !== 1'b0) $display("FAIL reset_release got out=%h busy=%b exp 0000/0", out0, busy0); else passed++;
  endtask

  task automatic test_inc_wrap();
    inc = 1'b1;
    repeat (3) tick();
    inc = 1'b0;
    total++; if (out0 !== 16'h0003 || out1 !== 16'h0003) $display("FAIL inc3 got %h/%h exp 0003", out0, out1); else passed++;
    load = 1'b1; in = 16'hFFFF; tick(); load = 1'b0;
    total++; if (wrap0 !== 1'b0 || out0 !== 16'hFFFF) $display("FAIL load_ffff got out=%h wrap=%b exp ffff/0", out0, wrap0); else passed++;
    inc = 1'b1; tick(); inc = 1'b0;
    total++; if (out0 !== 16'h0000 || wrap0 !== 1'b1) $display("FAIL inc_wrap got out=%h wrap=%b exp 0000/1", out0, wrap0); else passed++;
    total++; if (out1 !== 16'hFFFF || wrap1 !== 1'b1) $display("FAIL inc_sat got out=%h wrap=%b exp ffff/1", out1, wrap1); else passed++;
    tick();
    total++; if (wrap0 !== 1'b0 || wrap1 !== 1'b0) $display("FAIL wrap_pulse got %b/%b exp 0/0", wrap0, wrap1); else passed++;
  endtask

  task automatic test_dec_hold();
    load = 1'b1; in = 16'h0005; tick(); load = 1'b0;
    dec = 1'b1; tick(); tick(); dec = 1'b0;
    total++; if (out0 !== 16'h0003) $display("FAIL dec2 got %h exp 0003", out0); else passed++;
    inc = 1'b1; dec = 1'b1; tick(); inc = 1'b0; dec = 1'b0;
    total++; if (out0 !== 16'h0003 || wrap0 !== 1'b0) $display("FAIL incdec_hold got out=%h wrap=%b exp 0003/0", out0, wrap0); else passed++;
  endtask

  task automatic test_run();
    load = 1'b1; in = 16'h0010; term = 16'h0014; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    total++; if (busy0 !== 1'b1 || out0 !== 16'h0010) $display("FAIL run_start got busy=%b out=%h exp 1/0010", busy0, out0); else passed++;
    for (int v = 16'h11; v <= 16'h14; v++) begin
      tick();
      total++; if (out0 !== 16'(v)) $display("FAIL run_step got %h exp %h", out0, 16'(v)); else passed++;
      total++; if ({done0, busy0} !== ((v == 16'h14) ? 2'b10 : 2'b01)) $display("FAIL run_flags at %h got done/busy=%b%b", 16'(v), done0, busy0); else passed++;
    end
    total++; if (tc0 !== 1'b1) $display("FAIL run_tc got %b exp 1", tc0); else passed++;
    tick();
    total++; if (done0 !== 1'b0 || out0 !== 16'h0014) $display("FAIL run_after got done=%b out=%h exp 0/0014", done0, out0); else passed++;
  endtask

  task automatic test_start_eq_clear();
    load = 1'b1; in = 16'h0020; term = 16'h0020; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    total++; if ({busy0, done0} !== 2'b01 || out0 !== 16'h0020) $display("FAIL start_eq got busy/done=%b%b out=%h exp 01/0020", busy0, done0, out0); else passed++;
    tick();
    total++; if (done0 !== 1'b0) $display("FAIL start_eq_pulse got %b exp 0", done0); else passed++;
    load = 1'b1; in = 16'h0010; term = 16'h0030; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (done0 !== 1'b0 || busy0 !== 1'b1) $display("FAIL run_pre_clear got done=%b busy=%b exp 0/1", done0, busy0); else passed++;
    end
    clear = 1'b1; tick(); clear = 1'b0;
    total++; if (out0 !== 16'h0 || busy0 !== 1'b0 || done0 !== 1'b0) $display("FAIL clear_abort got out=%h busy=%b done=%b exp 0000/0/0", out0, busy0, done0); else passed++;
    tick();
    total++; if (done0 !== 1'b0) $display("FAIL clear_no_done got %b exp 0", done0); else passed++;
  endtask

  task automatic test_saturate();
    load = 1'b1; in = 16'hFFFE; term = 16'h0000; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    total++; if (out1 !== 16'hFFFF || busy1 !== 1'b1 || wrap1 !== 1'b0) $display("FAIL sat_step got out=%h busy=%b wrap=%b exp ffff/1/0", out1, busy1, wrap1); else passed++;
    tick();
    total++; if (out1 !== 16'hFFFF || {busy1, done1, wrap1} !== 3'b001) $display("FAIL sat_end got out=%h busy/done/wrap=%b exp ffff/001", out1, {busy1, done1, wrap1}); else passed++;
    total++; if (out0 !== 16'h0000 || {busy0, done0, wrap0} !== 3'b011) $display("FAIL wrap_run got out=%h busy/done/wrap=%b exp 0000/011", out0, {busy0, done0, wrap0}); else passed++;
    tick();
    total++; if (wrap1 !== 1'b0 || out1 !== 16'hFFFF) $display("FAIL sat_hold got out=%h wrap=%b exp ffff/0", out1, wrap1); else passed++;
    clear = 1'b1; tick(); clear = 1'b0;
    dec = 1'b1; tick(); dec = 1'b0;
    total++; if (out1 !== 16'h0000 || wrap1 !== 1'b1) $display("FAIL sat_dec got out=%h wrap=%b exp 0000/1", out1, wrap1); else passed++;
    total++; if (out0 !== 16'hFFFF || wrap0 !== 1'b1) $display("FAIL wrap_dec got out=%h wrap=%b exp ffff/1", out0, wrap0); else passed++;
  endtask

  task automatic test_async_reset();
    load = 1'b1; in = 16'h0100; term = 16'h0200; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    total++; if (busy0 !== 1'b1 || out0 !== 16'h0102) $display("FAIL pre_reset got busy=%b out=%h exp 1/0102", busy0, out0); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++; if (out0 !== 16'h0 || busy0 !== 1'b0 || out1 !== 16'h0 || busy1 !== 1'b0) $display("FAIL async_reset got out=%h/%h busy=%b/%b exp 0", out0, out1, busy0, busy1); else passed++;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({busy0, done0, busy1, done1} !== 4'b0 || out0 !== 16'h0) $display("FAIL post_reset got busy/done=%b out=%h exp 0000/0000", {busy0, done0, busy1, done1}, out0); else passed++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      int r;
      clear = ($urandom_range(0, 31) == 0);
      load  = ($urandom_range(0, 11) == 0);
      inc   = $urandom_range(0, 1) == 1;
      dec   = $urandom_range(0, 1) == 1;
      start = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 4);
      in = (r == 0) ? 16'hFFFF : (r == 1) ? 16'hFFFD : (r == 2) ? 16'h0001 : 16'($urandom);
      if ($urandom_range(0, 3) != 0) term = 16'(m_out[0] + $urandom_range(0, 6));
      else if ($urandom_range(0, 1) == 1) term = 16'($urandom);
      tick();
      total++; if (out0 !== 16'(m_out[0]) || out1 !== 16'(m_out[1])) $display("FAIL rnd_out cyc %0d got %h/%h exp %h/%h", c, out0, out1, 16'(m_out[0]), 16'(m_out[1])); else passed++;
      total++; if ({busy0, done0, wrap0} !== {m_run[0], m_done[0], m_wrap[0]}) $display("FAIL rnd_flags0 cyc %0d got %b exp %b", c, {busy0, done0, wrap0}, {m_run[0], m_done[0], m_wrap[0]}); else passed++;
      total++; if ({busy1, done1, wrap1} !== {m_run[1], m_done[1], m_wrap[1]}) $display("FAIL rnd_flags1 cyc %0d got %b exp %b", c, {busy1, done1, wrap1}, {m_run[1], m_done[1], m_wrap[1]}); else passed++;
      total++; if ({tc0, tc1} !== {m_out[0] == int'(term), m_out[1] == int'(term)}) $display("FAIL rnd_tc cyc %0d got %b%b", c, tc0, tc1); else passed++;
    end
    {clear, load, inc, dec, start} = '0;
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_dec_hold();
    test_run();
    test_start_eq_clear();
    test_saturate();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
